frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL have parameter ANGLE_INIT, default 0, giving the angle loaded at reset (0..359).
REQ-002 The block SHALL have parameter ANGLE_STEP, default 1, giving the angle increment per frame (1..359).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum number of cycles to wait for vs_done.
REQ-004 The block SHALL use one clock, clk_pix; reset is resetn, synchronous and active-low.
REQ-005 The block SHALL have these ports:
- clk_pix  in  1  pixel clock
- resetn  in  1  synchronous active-low reset
- vsync  in  1  active-low sync from the timing generator
- pause  in  1  holds the angle (see Configuration)
- vs_start  out  1  one-cycle start pulse to the vertex shader
- vs_done  in  1  vertex shader result valid
- vs_ax, vs_ay, vs_bx, vs_by, vs_cx, vs_cy  in  10 each  vertex shader results
- angle  out  9  current rotation angle, 0..359
- ax, ay, bx, by, cx, cy  out  10 each  committed vertices to the rasterizer
- verts_valid  out  1  at least one vertex set has been committed
- overrun_cnt  out  8  frames missed while waiting, saturating
- timeout_cnt  out  8  vertex shader timeouts, saturating

Function
REQ-006 tick SHALL be high when the registered previous vsync is 1 and the current vsync is 0.
REQ-007 The FSM states SHALL be IDLE, START, WAIT, HOLD, COMMIT and ADVANCE.
REQ-008 IDLE SHALL go to START on tick; the first frame uses ANGLE_INIT with no advance.
REQ-009 START SHALL drive vs_start=1 for exactly one cycle, clear the timeout counter and go to WAIT; vs_start SHALL be 0 in every other state.
REQ-010 On vs_done in WAIT, the block SHALL latch the vs_* inputs into capture registers, set pend=1 and go to HOLD, or to COMMIT if tick is high in the same cycle.
REQ-011 In WAIT, after TIMEOUT cycles with no vs_done, the block SHALL increment timeout_cnt (saturating at 255), set pend=0 and go to HOLD.
REQ-012 On tick in WAIT without vs_done, the block SHALL increment overrun_cnt (saturating at 255) and stay in WAIT.
REQ-013 vs_done outside WAIT SHALL be ignored.
REQ-014 HOLD SHALL go to COMMIT on tick.
REQ-015 In COMMIT, if pend=1 the block SHALL copy the capture registers to ax..cy, set verts_valid=1 and clear pend; then go to ADVANCE.
REQ-016 If pend=0 in COMMIT, ax..cy SHALL keep their previous values.
REQ-017 In ADVANCE, angle SHALL become (angle+ANGLE_STEP) mod 360, computed as an unsigned 10-bit sum with 360 subtracted when the sum is 360 or more; then go to START.
REQ-018 angle SHALL change only in ADVANCE, so it is stable from START through WAIT.
REQ-019 ax..cy SHALL change only in COMMIT, which is one edge after the HOLD->COMMIT edge, i.e. in vertical blanking.

Reset
REQ-020 When resetn=0 at a clk_pix edge, the block SHALL set: state=IDLE, angle=ANGLE_INIT, ax..cy=0, verts_valid=0, vs_start=0, pend=0, overrun_cnt=0, timeout_cnt=0, and the vsync history register=0.
REQ-021 Because the history register resets to 0, there SHALL be no tick until vsync has been sampled high at least once after reset.
REQ-022 Reset asserted mid-WAIT SHALL abandon the computation; a later vs_done SHALL be ignored until the next START.

Configuration
REQ-023 With PAUSE_EN defined, pause=1 in ADVANCE SHALL hold angle unchanged, while recompute and commit still run every frame.
REQ-024 Without PAUSE_EN, the pause port SHALL still exist but be ignored, and angle SHALL advance every frame.

Structure
REQ-025 Package raster_pkg SHALL hold ANGLE_MOD=360, the coordinate width 10, the angle width 9 and the FSM state enum.
REQ-026 The vsync falling-edge detector SHALL be a sub-module named frame_tick (register plus edge logic).

Verification
REQ-027 Reset, then vsync 1->0 -> vs_start pulse two edges later, with angle=0.
REQ-028 vs_done with vs_ax=100, then a second tick -> ax=100 two edges after that tick, verts_valid=1, angle=1 one edge later.
REQ-029 ANGLE_STEP=7, angle=357 -> angle=4 after the next ADVANCE.
REQ-030 No vs_done and TIMEOUT=16 -> timeout_cnt=1, ax..cy unchanged after the next COMMIT.
REQ-031 Three ticks during WAIT -> overrun_cnt=3, angle unchanged; with overrun_cnt=255, a further tick leaves it at 255.
REQ-032 vs_done and tick in the same cycle -> COMMIT next cycle with the new vertices; PAUSE_EN with pause=1 -> angle constant over 5 frames while vs_start still pulses each frame.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared widths, FSM state encoding and small arithmetic helpers for the frame sequencer.
package raster_pkg;

  localparam int ANGLE_MOD = 360;
  localparam int COORD_W   = 10;
  localparam int ANGLE_W   = 9;
  localparam logic [ANGLE_W:0] ANGLE_MOD_SUM = 10'd360;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    COMMIT  = 3'd4,
    ADVANCE = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] ax;
    logic [COORD_W-1:0] ay;
    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
  } verts_t;

  // Angle wrap uses a 10-bit sum so any step below 360 folds back with one subtraction.
  function automatic logic [ANGLE_W-1:0] angle_add(input logic [ANGLE_W-1:0] angle,
                                                   input logic [ANGLE_W-1:0] step);
    logic [ANGLE_W:0] sum;
    sum = {1'b0, angle} + {1'b0, step};
    if (sum >= ANGLE_MOD_SUM) begin
      sum = sum - ANGLE_MOD_SUM;
    end
    return sum[ANGLE_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Falling-edge detector on the active-low vsync; one-cycle tick marks the start of a frame.
module frame_tick (
  input  logic clk_pix,
  input  logic resetn,
  input  logic vsync,
  output logic tick
);

  logic vsync_prev_r;

  // History register clears to 0 so no tick fires until vsync has been seen high.
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      vsync_prev_r <= 1'b0;
    end else begin
      vsync_prev_r <= vsync;
    end
  end

  assign tick = vsync_prev_r & ~vsync;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: starts the vertex shader, waits for its result and commits the
// vertices in vertical blanking, then advances the angle. Macro PAUSE_EN lets pause freeze the angle.
module frame_sequencer
  import raster_pkg::*;
#(
  parameter int ANGLE_INIT = 0,
  parameter int ANGLE_STEP = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk_pix,
  input  logic               resetn,
  input  logic               vsync,
  input  logic               pause,
  output logic               vs_start,
  input  logic               vs_done,
  input  logic [COORD_W-1:0] vs_ax,
  input  logic [COORD_W-1:0] vs_ay,
  input  logic [COORD_W-1:0] vs_bx,
  input  logic [COORD_W-1:0] vs_by,
  input  logic [COORD_W-1:0] vs_cx,
  input  logic [COORD_W-1:0] vs_cy,
  output logic [ANGLE_W-1:0] angle,
  output logic [COORD_W-1:0] ax,
  output logic [COORD_W-1:0] ay,
  output logic [COORD_W-1:0] bx,
  output logic [COORD_W-1:0] by,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               verts_valid,
  output logic [7:0]         overrun_cnt,
  output logic [7:0]         timeout_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e         state_r, state_s;
  logic [ANGLE_W-1:0] angle_r, angle_s;
  verts_t             cap_r, cap_s, verts_r, verts_s, vs_in_s;
  logic               valid_r, valid_s, pend_r, pend_s, vs_start_r, vs_start_s;
  logic [7:0]         overrun_r, overrun_s, timeout_r, timeout_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic               tick;
  logic               hold_angle_s;

  frame_tick u_frame_tick (
    .clk_pix(clk_pix),
    .resetn (resetn),
    .vsync  (vsync),
    .tick   (tick)
  );

`ifdef PAUSE_EN
  assign hold_angle_s = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold_angle_s = 1'b0;
`endif

  assign vs_in_s = {vs_ax, vs_ay, vs_bx, vs_by, vs_cx, vs_cy};

  // State and datapath registers; all outputs come straight from these.
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      state_r    <= IDLE;
      angle_r    <= ANGLE_W'(ANGLE_INIT);
      cap_r      <= '0;
      verts_r    <= '0;
      valid_r    <= 1'b0;
      pend_r     <= 1'b0;
      vs_start_r <= 1'b0;
      overrun_r  <= 8'd0;
      timeout_r  <= 8'd0;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      angle_r    <= angle_s;
      cap_r      <= cap_s;
      verts_r    <= verts_s;
      valid_r    <= valid_s;
      pend_r     <= pend_s;
      vs_start_r <= vs_start_s;
      overrun_r  <= overrun_s;
      timeout_r  <= timeout_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Next-state and next-datapath values; every register holds unless its state acts on it.
  always_comb begin
    state_s    = state_r;
    angle_s    = angle_r;
    cap_s      = cap_r;
    verts_s    = verts_r;
    valid_s    = valid_r;
    pend_s     = pend_r;
    vs_start_s = 1'b0;
    overrun_s  = overrun_r;
    timeout_s  = timeout_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (tick) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        vs_start_s = 1'b1;
        wait_cnt_s = '0;
        state_s    = WAIT;
      end
      WAIT: begin
        if (vs_done) begin
          cap_s  = vs_in_s;
          pend_s = 1'b1;
          state_s = tick ? COMMIT : HOLD;
        end else begin
          // A frame boundary coinciding with the timeout counts as both events.
          if (tick) begin
            overrun_s = sat_inc8(overrun_r);
          end else begin
            overrun_s = overrun_r;
          end
          if (wait_cnt_r == WAIT_W'(TIMEOUT - 1)) begin
            timeout_s = sat_inc8(timeout_r);
            pend_s    = 1'b0;
            state_s   = HOLD;
          end else begin
            wait_cnt_s = wait_cnt_r + WAIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_s = COMMIT;
        end else begin
          state_s = HOLD;
        end
      end
      COMMIT: begin
        if (pend_r) begin
          verts_s = cap_r;
          valid_s = 1'b1;
          pend_s  = 1'b0;
        end else begin
          verts_s = verts_r;
        end
        state_s = ADVANCE;
      end
      ADVANCE: begin
        if (hold_angle_s) begin
          angle_s = angle_r;
        end else begin
          angle_s = angle_add(angle_r, ANGLE_W'(ANGLE_STEP));
        end
        state_s = START;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign vs_start    = vs_start_r;
  assign angle       = angle_r;
  assign ax          = verts_r.ax;
  assign ay          = verts_r.ay;
  assign bx          = verts_r.bx;
  assign by          = verts_r.by;
  assign cx          = verts_r.cx;
  assign cy          = verts_r.cy;
  assign verts_valid = valid_r;
  assign overrun_cnt = overrun_r;
  assign timeout_cnt = timeout_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: two parameterisations share stimulus; a frame-level reference
// model is compared every cycle, plus a vector table and directed corner-case sequences.
module tb_frame_sequencer;

`ifdef PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic       clk_pix = 1'b0;
  logic       resetn, vsync, pause, vs_done;
  logic [9:0] vin [6];
  logic       vs_start_o [2];
  logic [8:0] angle_o [2];
  logic [9:0] vout [2][6];
  logic       valid_o [2];
  logic [7:0] ovr_o [2];
  logic [7:0] tmo_o [2];

  int checks = 0;
  int errors = 0;
  int per;
  int saved_ax, saved_cy, saved_y;

  int p_init [2];
  int p_step [2];
  int p_tmo  [2];

  // Reference model: frame-level bookkeeping, angle derived from the count of advances.
  bit m_prev;
  bit m_idle [2];
  bit m_wait [2];
  bit m_hold [2];
  bit m_pend [2];
  bit m_valid [2];
  bit m_vs_start [2];
  int m_after [2];
  int m_age [2];
  int m_ovr [2];
  int m_tmo [2];
  int m_nadv [2];
  int m_cap [2][6];
  int m_out [2][6];

  typedef struct {
    bit rst_n;
    bit vs;
    bit done;
    int ax_in;
    bit e_start;
    int e_angle;
    int e_ax;
    bit e_valid;
  } vec_t;
  vec_t tbl [12];

  always #5 clk_pix = ~clk_pix;

  frame_sequencer #(.ANGLE_INIT(0), .ANGLE_STEP(1), .TIMEOUT(16)) dut_a (
    .clk_pix(clk_pix), .resetn(resetn), .vsync(vsync), .pause(pause),
    .vs_start(vs_start_o[0]), .vs_done(vs_done),
    .vs_ax(vin[0]), .vs_ay(vin[1]), .vs_bx(vin[2]), .vs_by(vin[3]), .vs_cx(vin[4]), .vs_cy(vin[5]),
    .angle(angle_o[0]),
    .ax(vout[0][0]), .ay(vout[0][1]), .bx(vout[0][2]), .by(vout[0][3]), .cx(vout[0][4]), .cy(vout[0][5]),
    .verts_valid(valid_o[0]), .overrun_cnt(ovr_o[0]), .timeout_cnt(tmo_o[0])
  );

  frame_sequencer #(.ANGLE_INIT(350), .ANGLE_STEP(7), .TIMEOUT(1024)) dut_b (
    .clk_pix(clk_pix), .resetn(resetn), .vsync(vsync), .pause(pause),
    .vs_start(vs_start_o[1]), .vs_done(vs_done),
    .vs_ax(vin[0]), .vs_ay(vin[1]), .vs_bx(vin[2]), .vs_by(vin[3]), .vs_cx(vin[4]), .vs_cy(vin[5]),
    .angle(angle_o[1]),
    .ax(vout[1][0]), .ay(vout[1][1]), .bx(vout[1][2]), .by(vout[1][3]), .cx(vout[1][4]), .cy(vout[1][5]),
    .verts_valid(valid_o[1]), .overrun_cnt(ovr_o[1]), .timeout_cnt(tmo_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // m_after counts through the blanking chain: 1 commit, 2 advance, 3 start pulse.
  task automatic model_edge();
    bit tk;
    tk = m_prev && !vsync;
    m_prev = resetn ? vsync : 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_vs_start[i] = 1'b0;
      if (!resetn) begin
        m_idle[i] = 1'b1; m_wait[i] = 1'b0; m_hold[i] = 1'b0; m_after[i] = 0;
        m_pend[i] = 1'b0; m_valid[i] = 1'b0; m_ovr[i] = 0; m_tmo[i] = 0; m_nadv[i] = 0;
        for (int j = 0; j < 6; j++) m_out[i][j] = 0;
      end else if (m_idle[i]) begin
        if (tk) begin
          m_idle[i] = 1'b0;
          m_after[i] = 3;
        end
      end else if (m_after[i] == 1) begin
        if (m_pend[i]) begin
          for (int j = 0; j < 6; j++) m_out[i][j] = m_cap[i][j];
          m_valid[i] = 1'b1;
          m_pend[i] = 1'b0;
        end
        m_after[i] = 2;
      end else if (m_after[i] == 2) begin
        if (!(PAUSE_ON && pause)) m_nadv[i]++;
        m_after[i] = 3;
      end else if (m_after[i] == 3) begin
        m_vs_start[i] = 1'b1;
        m_wait[i] = 1'b1;
        m_age[i] = 0;
        m_after[i] = 0;
      end else if (m_wait[i]) begin
        m_age[i]++;
        if (vs_done) begin
          for (int j = 0; j < 6; j++) m_cap[i][j] = int'(vin[j]);
          m_pend[i] = 1'b1;
          m_wait[i] = 1'b0;
          if (tk) m_after[i] = 1;
          else m_hold[i] = 1'b1;
        end else begin
          if (tk) m_ovr[i] = sat(m_ovr[i]);
          if (m_age[i] == p_tmo[i]) begin
            m_tmo[i] = sat(m_tmo[i]);
            m_pend[i] = 1'b0;
            m_wait[i] = 1'b0;
            m_hold[i] = 1'b1;
          end
        end
      end else if (m_hold[i]) begin
        if (tk) begin
          m_hold[i] = 1'b0;
          m_after[i] = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
    model_edge();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_vs_start[%0d]", i), int'(vs_start_o[i]), int'(m_vs_start[i]));
      chk($sformatf("model_angle[%0d]", i), int'(angle_o[i]), (p_init[i] + p_step[i] * m_nadv[i]) % 360);
      for (int j = 0; j < 6; j++)
        chk($sformatf("model_vert[%0d][%0d]", i, j), int'(vout[i][j]), m_out[i][j]);
      chk($sformatf("model_valid[%0d]", i), int'(valid_o[i]), int'(m_valid[i]));
      chk($sformatf("model_overrun[%0d]", i), int'(ovr_o[i]), m_ovr[i]);
      chk($sformatf("model_timeout[%0d]", i), int'(tmo_o[i]), m_tmo[i]);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; vsync = 1'b0; vs_done = 1'b0; pause = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic tick_frame();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  // Entered with the sequencer in START; leaves it in START for the following frame.
  task automatic frame(input bit done);
    step();
    chk("frame_vs_start", int'(vs_start_o[0]), 1);
    if (done) begin
      vs_done = 1'b1;
      step();
      vs_done = 1'b0;
    end else begin
      vsync = 1'b1;
      repeat (20) step();
    end
    tick_frame();
    step();
    step();
  endtask

  initial begin
    p_init[0] = 0;   p_step[0] = 1; p_tmo[0] = 16;
    p_init[1] = 350; p_step[1] = 7; p_tmo[1] = 1024;
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1'b1; m_wait[i] = 1'b0; m_hold[i] = 1'b0; m_pend[i] = 1'b0; m_valid[i] = 1'b0;
      m_after[i] = 0; m_age[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0; m_nadv[i] = 0;
      for (int j = 0; j < 6; j++) begin
        m_cap[i][j] = 0;
        m_out[i][j] = 0;
      end
    end
    resetn = 1'b0; vsync = 1'b0; vs_done = 1'b0; pause = 1'b0;
    for (int j = 0; j < 6; j++) vin[j] = 10'd0;

    // rst_n, vsync, done, ax_in | vs_start, angle, ax, valid  (instance with step 1)
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0,   1'b0, 0, 0,   1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0,   1'b0, 0, 0,   1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 0,   1'b0, 0, 0,   1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 0,   1'b0, 0, 0,   1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 0,   1'b1, 0, 0,   1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 100, 1'b0, 0, 0,   1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 0,   1'b0, 0, 0,   1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 0,   1'b0, 0, 0,   1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0,   1'b0, 0, 100, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 0,   1'b0, 1, 100, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 0,   1'b1, 1, 100, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 200, 1'b0, 1, 100, 1'b1};

    for (int r = 0; r < 12; r++) begin
      resetn = tbl[r].rst_n;
      vsync = tbl[r].vs;
      vs_done = tbl[r].done;
      vin[0] = 10'(tbl[r].ax_in);
      step();
      chk($sformatf("tbl%0d_vs_start", r), int'(vs_start_o[0]), int'(tbl[r].e_start));
      chk($sformatf("tbl%0d_angle", r), int'(angle_o[0]), tbl[r].e_angle);
      chk($sformatf("tbl%0d_ax", r), int'(vout[0][0]), tbl[r].e_ax);
      chk($sformatf("tbl%0d_valid", r), int'(valid_o[0]), int'(tbl[r].e_valid));
    end
    vs_done = 1'b0;

    // Angle wrap: 350 -> 357 -> 4 with step 7.
    do_reset();
    tick_frame();
    frame(1'b1);
    chk("wrap_angle_357", int'(angle_o[1]), 357);
    chk("step1_angle_1", int'(angle_o[0]), 1);
    frame(1'b1);
    chk("wrap_angle_4", int'(angle_o[1]), 4);

    // Timeout: the committed vertices survive a frame with no shader result.
    do_reset();
    for (int j = 0; j < 6; j++) vin[j] = 10'($urandom_range(0, 1023));
    saved_ax = int'(vin[0]);
    saved_cy = int'(vin[5]);
    tick_frame();
    frame(1'b1);
    chk("commit_ax", int'(vout[0][0]), saved_ax);
    for (int j = 0; j < 6; j++) vin[j] = ~vin[j];
    step();
    vsync = 1'b1;
    repeat (20) step();
    chk("timeout_cnt_1", int'(tmo_o[0]), 1);
    tick_frame();
    step();
    chk("timeout_keep_ax", int'(vout[0][0]), saved_ax);
    chk("timeout_keep_cy", int'(vout[0][5]), saved_cy);

    // Overruns while waiting, then saturation at 255.
    do_reset();
    tick_frame();
    step();
    repeat (3) tick_frame();
    chk("overrun_3", int'(ovr_o[1]), 3);
    chk("overrun_3_angle", int'(angle_o[1]), 350);
    repeat (260) tick_frame();
    chk("overrun_sat", int'(ovr_o[1]), 255);

    // Result and frame boundary in the same cycle commit on the very next edge.
    do_reset();
    tick_frame();
    step();
    vsync = 1'b1;
    step();
    for (int j = 0; j < 6; j++) vin[j] = 10'($urandom_range(1, 1023));
    saved_y = int'(vin[0]);
    vs_done = 1'b1;
    vsync = 1'b0;
    step();
    vs_done = 1'b0;
    chk("same_cycle_before", int'(vout[0][0]), 0);
    step();
    chk("same_cycle_ax", int'(vout[0][0]), saved_y);
    chk("same_cycle_valid", int'(valid_o[0]), 1);

    // Pause over five frames.
    do_reset();
    pause = 1'b1;
    tick_frame();
    repeat (5) frame(1'b1);
    chk("pause_angle", int'(angle_o[0]), PAUSE_ON ? 0 : 5);
    pause = 1'b0;

    // Randomized traffic against the model, including occasional mid-frame resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0: per = 3;
        1: per = 12;
        default: per = 30;
      endcase
      vsync = ($urandom_range(0, per) != 0);
      vs_done = ($urandom_range(0, 9) == 0);
      pause = 1'($urandom_range(0, 1));
      resetn = ($urandom_range(0, 999) != 0);
      for (int j = 0; j < 6; j++) vin[j] = 10'($urandom_range(0, 1023));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
